// File: rtl/rf_2p_fifo_ctrl.sv
`timescale 1ns/1ps
// Valid/ready FIFO controller driving a 2-port RF macro, with a 2-entry registered output buffer hiding the 1-cycle read latency.
// Latency: push at t -> o_dval at t+3; push stalls when the RF is full; pop-side stall is absorbed by the output buffer.
module rf_2p_fifo_ctrl #(
    parameter int WORDWD = 12,
    parameter int DWD    = 16,
    parameter int AWD    = $clog2(WORDWD),
    parameter int SIZE   = 1,
    parameter int CWD    = $clog2(WORDWD + 3)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_clear,
    input  logic                     i_dval,
    output logic                     o_drdy,
    input  logic [SIZE-1:0][DWD-1:0] i_data,
    output logic                     o_dval,
    input  logic                     i_drdy,
    output logic [SIZE-1:0][DWD-1:0] o_data,
    output logic [CWD-1:0]           o_count,
    output logic                     o_rf_read,
    output logic                     o_rf_write,
    output logic [AWD-1:0]           o_rf_raddr,
    output logic [AWD-1:0]           o_rf_waddr,
    output logic [SIZE-1:0][DWD-1:0] o_rf_wdata,
    input  logic [SIZE-1:0][DWD-1:0] i_rf_rdata
);

    typedef logic [SIZE-1:0][DWD-1:0] word_t;

    logic [AWD-1:0] wptr_q, wptr_d;
    logic [AWD-1:0] rptr_q, rptr_d;
    logic [CWD-1:0] rf_cnt_q, rf_cnt_d;
    logic [CWD-1:0] count_q, count_d;
    logic           inflight_q, inflight_d;
    logic [1:0]     ob_cnt_q, ob_cnt_d;
    word_t          ob0_q, ob0_d;
    word_t          ob1_q, ob1_d;

    logic push_hs;
    logic pop_hs;
    logic rd_en;

    function automatic logic [AWD-1:0] ptr_inc(input logic [AWD-1:0] p);
        return (p == AWD'(WORDWD - 1)) ? '0 : p + AWD'(1);
    endfunction

    assign o_drdy  = !i_clear && (rf_cnt_q < CWD'(WORDWD));
    assign o_dval  = (ob_cnt_q != 2'd0);
    assign push_hs = i_rst_n && i_dval && o_drdy;
    assign pop_hs  = o_dval && i_drdy;

    // Issue a read only if the word will have a buffer slot when it lands.
    assign rd_en = i_rst_n && (rf_cnt_q != '0)
                 && ((3'(ob_cnt_q) + 3'(inflight_q)) < (3'd2 + 3'(pop_hs)));

    assign o_rf_read  = rd_en;
    assign o_rf_write = push_hs;
    assign o_rf_raddr = rptr_q;
    assign o_rf_waddr = wptr_q;
    assign o_rf_wdata = i_data;
    assign o_data     = ob0_q;
    assign o_count    = count_q;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        rf_cnt_d   = rf_cnt_q + CWD'(push_hs) - CWD'(rd_en);
        inflight_d = rd_en;
        ob_cnt_d   = ob_cnt_q;
        ob0_d      = ob0_q;
        ob1_d      = ob1_q;
        if (push_hs) begin
            wptr_d = ptr_inc(wptr_q);
        end
        if (rd_en) begin
            rptr_d = ptr_inc(rptr_q);
        end
        if (pop_hs) begin
            ob_cnt_d = ob_cnt_q - 2'd1;
            if (ob_cnt_q == 2'd2) begin
                ob0_d = ob1_q;
            end
        end
        // Landing word goes to the first slot left free after this cycle's pop.
        if (inflight_q) begin
            if (ob_cnt_d == 2'd0) begin
                ob0_d = i_rf_rdata;
            end else begin
                ob1_d = i_rf_rdata;
            end
            ob_cnt_d = ob_cnt_d + 2'd1;
        end
        count_d = rf_cnt_d + CWD'(inflight_d) + CWD'(ob_cnt_d);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            rf_cnt_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            ob_cnt_q   <= 2'd0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            rf_cnt_q   <= rf_cnt_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            ob_cnt_q   <= ob_cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        ob0_q <= ob0_d;
        ob1_q <= ob1_d;
    end

`ifndef SYNTHESIS
    a_no_same_addr: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (o_rf_read && o_rf_write) |-> (o_rf_raddr != o_rf_waddr));
`endif

endmodule

// File: tb/tb_rf_2p_fifo_ctrl.sv
`timescale 1ns/1ps
// Randomised and directed bench for rf_2p_fifo_ctrl with an RF macro model and a queue-based FIFO reference.
module tb_rf_2p_fifo_ctrl;

    localparam int W   = 12;
    localparam int DW  = 16;
    localparam int AW  = $clog2(W);
    localparam int CW  = $clog2(W + 3);

    logic          clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_clear = 1'b0;
    logic          i_dval = 1'b0;
    logic          i_drdy = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          o_drdy, o_dval, o_rf_read, o_rf_write;
    logic [DW-1:0] o_data, o_rf_wdata;
    logic [DW-1:0] rf_rdata;
    logic [CW-1:0] o_count;
    logic [AW-1:0] o_rf_raddr, o_rf_waddr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rf_2p_fifo_ctrl #(.WORDWD(W), .DWD(DW), .SIZE(1)) dut (
        .i_clk      (clk),
        .i_rst_n    (i_rst_n),
        .i_clear    (i_clear),
        .i_dval     (i_dval),
        .o_drdy     (o_drdy),
        .i_data     (i_data),
        .o_dval     (o_dval),
        .i_drdy     (i_drdy),
        .o_data     (o_data),
        .o_count    (o_count),
        .o_rf_read  (o_rf_read),
        .o_rf_write (o_rf_write),
        .o_rf_raddr (o_rf_raddr),
        .o_rf_waddr (o_rf_waddr),
        .o_rf_wdata (o_rf_wdata),
        .i_rf_rdata (rf_rdata)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // RF macro: 1-cycle read latency, X on same-address read+write.
    logic [DW-1:0] mem [0:W-1];
    always @(posedge clk) begin
        if (o_rf_write) mem[o_rf_waddr] <= o_rf_wdata;
        if (o_rf_read) begin
            if (o_rf_write && (o_rf_raddr == o_rf_waddr)) rf_rdata <= 'x;
            else rf_rdata <= mem[o_rf_raddr];
        end
    end

    // Reference: words in the RF, the word in flight, and the output buffer, as queues.
    logic [DW-1:0] rfq[$];
    logic [DW-1:0] flyq[$];
    logic [DW-1:0] obq[$];
    logic [DW-1:0] popped[$];
    int  wcnt = 0;
    int  rcnt = 0;
    int  pop_cnt = 0;
    bit  started = 0;

    always @(posedge clk) if (!i_rst_n) started <= 1'b1;

    always @(negedge clk) begin
        bit e_drdy, e_push, e_pop, pop_raw, e_rd;
        if (started) begin
            e_drdy  = (rfq.size() < W) && !i_clear;
            e_push  = i_rst_n && i_dval && e_drdy;
            pop_raw = (obq.size() != 0) && i_drdy;
            e_pop   = i_rst_n && !i_clear && pop_raw;
            e_rd    = i_rst_n && (rfq.size() != 0)
                      && (obq.size() + flyq.size() < 2 + int'(pop_raw));
            chk("o_drdy", 64'(o_drdy), 64'(e_drdy));
            chk("o_dval", 64'(o_dval), 64'(obq.size() != 0));
            chk("o_count", 64'(o_count), 64'(rfq.size() + flyq.size() + obq.size()));
            chk("o_rf_read", 64'(o_rf_read), 64'(e_rd));
            chk("o_rf_write", 64'(o_rf_write), 64'(e_push));
            if (e_rd) chk("o_rf_raddr", 64'(o_rf_raddr), 64'(rcnt));
            if (e_push) begin
                chk("o_rf_waddr", 64'(o_rf_waddr), 64'(wcnt));
                chk("o_rf_wdata", 64'(o_rf_wdata), 64'(i_data));
            end
            if (obq.size() != 0) chk("o_data", 64'(o_data), 64'(obq[0]));
            if (o_rf_read && o_rf_write) chk("rf_collision", 64'(o_rf_raddr != o_rf_waddr), 64'd1);
            if (!i_rst_n || i_clear) begin
                rfq.delete(); flyq.delete(); obq.delete();
                wcnt = 0; rcnt = 0;
            end else begin
                if (e_pop) begin
                    popped.push_back(obq[0]);
                    pop_cnt++;
                    void'(obq.pop_front());
                end
                if (flyq.size() != 0) obq.push_back(flyq.pop_front());
                if (e_rd) begin
                    flyq.push_back(rfq.pop_front());
                    rcnt = (rcnt + 1) % W;
                end
                if (e_push) begin
                    rfq.push_back(i_data);
                    wcnt = (wcnt + 1) % W;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] sent[$];
        int n, budget, first_dval, p0;
        bit seen;

        // Reset held with push valid asserted
        i_rst_n = 1'b0; i_dval = 1'b1; i_data = 16'h5A5A;
        repeat (5) cyc();
        #1;
        chk("t1_rf_write", 64'(o_rf_write), 64'd0);
        chk("t1_dval", 64'(o_dval), 64'd0);
        chk("t1_count", 64'(o_count), 64'd0);
        chk("t1_drdy", 64'(o_drdy), 64'd1);
        cyc();
        i_rst_n = 1'b1; i_dval = 1'b0;
        cyc();

        // Fill with pop stalled
        popped.delete();
        n = 0; budget = 100;
        while (n < 14 && budget > 0) begin
            i_dval = 1'b1; i_data = DW'(n + 1);
            #1;
            if (o_drdy) n++;
            budget--;
            cyc();
        end
        chk("t2_accepted", 64'(n), 64'd14);
        i_dval = 1'b1; i_data = 16'h00FF;
        repeat (3) cyc();
        chk("t2_drdy_full", 64'(o_drdy), 64'd0);
        chk("t2_count_full", 64'(o_count), 64'd14);
        i_dval = 1'b0;

        // Single pop at full
        i_drdy = 1'b1;
        #1;
        chk("t5_pop_dval", 64'(o_dval), 64'd1);
        chk("t5_read", 64'(o_rf_read), 64'd1);
        cyc();
        i_drdy = 1'b0;
        #1;
        chk("t5_drdy_after", 64'(o_drdy), 64'd1);
        chk("t5_count", 64'(o_count), 64'd13);
        i_dval = 1'b1; i_data = 16'h000F;
        cyc();
        i_dval = 1'b0;

        // Drain
        i_drdy = 1'b1;
        budget = 200;
        while (o_count != 0 && budget > 0) begin cyc(); budget--; end
        chk("t2_drain_timeout", 64'(budget != 0), 64'd1);
        i_drdy = 1'b0;
        chk("t2_pop_total", 64'(popped.size()), 64'd15);
        for (int i = 0; i < popped.size() && i < 15; i++)
            chk("t2_order", 64'(popped[i]), 64'(i + 1));
        cyc();

        // Streaming
        i_clear = 1'b1; cyc(); i_clear = 1'b0;
        popped.delete();
        p0 = pop_cnt; first_dval = -1;
        for (int c = 0; c < 100; c++) begin
            i_dval = 1'b1; i_drdy = 1'b1; i_data = DW'(c);
            #1;
            if (o_dval && first_dval < 0) first_dval = c;
            cyc();
        end
        chk("t3_first_dval", 64'(first_dval), 64'd3);
        chk("t3_pops", 64'(pop_cnt - p0), 64'd97);
        for (int i = 0; i < popped.size(); i++)
            chk("t3_order", 64'(popped[i]), 64'(i));
        i_dval = 1'b0;
        budget = 50;
        while (o_count != 0 && budget > 0) begin cyc(); budget--; end
        chk("t3_drain_timeout", 64'(budget != 0), 64'd1);

        // Random handshakes across several pointer wraps
        popped.delete(); sent.delete();
        n = 0; budget = 3000;
        while ((n < 3 * W + 5 || o_count != 0) && budget > 0) begin
            i_dval = (n < 3 * W + 5) && ($urandom_range(0, 1) == 1);
            i_data = DW'($urandom);
            i_drdy = ($urandom_range(0, 1) == 1);
            #1;
            if (i_dval && o_drdy) begin sent.push_back(i_data); n++; end
            budget--;
            cyc();
        end
        i_dval = 1'b0; i_drdy = 1'b0;
        chk("t4_timeout", 64'(budget != 0), 64'd1);
        chk("t4_pop_total", 64'(popped.size()), 64'(3 * W + 5));
        for (int i = 0; i < popped.size() && i < sent.size(); i++)
            chk("t4_data", 64'(popped[i]), 64'(sent[i]));
        cyc();

        // Clear while a read is in flight
        i_dval = 1'b1; i_data = 16'h1111;
        cyc();
        i_dval = 1'b0;
        #1;
        chk("t6_read_before_clear", 64'(o_rf_read), 64'd1);
        i_clear = 1'b1;
        cyc();
        i_clear = 1'b0;
        #1;
        chk("t6_dval_after_clear", 64'(o_dval), 64'd0);
        chk("t6_count_after_clear", 64'(o_count), 64'd0);
        repeat (3) cyc();
        chk("t6_landed_ignored", 64'(o_dval), 64'd0);
        i_dval = 1'b1; i_data = 16'hABCD;
        cyc();
        i_dval = 1'b0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            #1;
            if (o_dval) seen = 1;
            else cyc();
        end
        chk("t6_dval_seen", 64'(seen), 64'd1);
        chk("t6_data", 64'(o_data), 64'hABCD);
        i_drdy = 1'b1;
        cyc();
        i_drdy = 1'b0;
        repeat (2) cyc();
        chk("t6_count_end", 64'(o_count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
